// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//   Centisecond stopwatch. It sits directly downstream of the 100 Hz divider
//   and runs entirely on clk. The divided clock is only sampled: each rising
//   edge of clk_100hz becomes a one-cycle 10 ms tick. The block keeps a BCD
//   mm:ss.cc count, with run/pause, lap-hold freeze and clear control, and
//   feeds the value to the display scanner.
//
// Parameters
//   MAX_MIN     highest minute value before the count wraps (1..99)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   clk_100hz   divided clock, sampled only
//   start_stop  one-cycle pulse, toggles between run and pause
//   lap         one-cycle pulse, toggles the lap-hold display freeze
//   clear       one-cycle pulse, zeroes the count when not running
//   disp_bcd    displayed value {m1,m0,s1,s0,c1,c0}, 4 bits per digit
//   running     high while the stopwatch is in RUN
//   lap_hold    high while the display is frozen on the lap latch
//   overflow    sticky; set when the count wraps past MAX_MIN:59.99
//   state       IDLE=00, RUN=01, PAUSE=10 (11 recovers to IDLE)
//
// FSM states
//   state | meaning
//   IDLE  | count is zero, waiting for start_stop
//   RUN   | counting ticks, lap toggles the display freeze
//   PAUSE | count held, clear returns to IDLE
//   BAD   | unused encoding, returns to IDLE on the next edge
// ---------------------------------------------------------------------------
module stopwatch_core #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_100hz,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  // -------------------------------------------------------------------------
  // Tick generation: two-flop synchronizer plus an edge-detect delay flop.
  // -------------------------------------------------------------------------
  logic sync0, sync1, sync2;
  logic tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync0 <= clk_100hz;
      sync1 <= sync0;
      sync2 <= sync1;
    end
  end

  assign tick = sync1 & ~sync2;

  // -------------------------------------------------------------------------
  // BCD count and its incremented value
  // -------------------------------------------------------------------------
  logic [3:0] m1, m0, s1, s0, c1, c0;
  logic [23:0] cnt_q, cnt_inc, latch_q;
  logic cy_c0, cy_c1, cy_s0, cy_s1, cy_m0;
  logic at_max;

  assign {m1, m0, s1, s0, c1, c0} = cnt_q;

  always_comb begin
    cy_c0  = (c0 == 4'd9);
    cy_c1  = cy_c0 && (c1 == 4'd9);
    cy_s0  = cy_c1 && (s0 == 4'd9);
    cy_s1  = cy_s0 && (s1 == 4'd5);
    cy_m0  = cy_s1 && (m0 == 4'd9);
    // Wrap is decided on the whole value so m1 never goes past the
    // tens digit of MAX_MIN and m0 never past its units digit there.
    at_max = cy_s1 && (m1 == MAX_M1) && (m0 == MAX_M0);

    cnt_inc = cnt_q;
    if (at_max) begin
      cnt_inc = '0;
    end else begin
      cnt_inc[3:0] = cy_c0 ? 4'd0 : c0 + 4'd1;
      if (cy_c0) cnt_inc[7:4]   = cy_c1 ? 4'd0 : c1 + 4'd1;
      if (cy_c1) cnt_inc[11:8]  = cy_s0 ? 4'd0 : s0 + 4'd1;
      if (cy_s0) cnt_inc[15:12] = cy_s1 ? 4'd0 : s1 + 4'd1;
      if (cy_s1) cnt_inc[19:16] = cy_m0 ? 4'd0 : m0 + 4'd1;
      if (cy_m0) cnt_inc[23:20] = m1 + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_t state_q, state_n;
  logic   lap_hold_q, lap_hold_n;
  logic   running_q;
  logic   overflow_q;
  logic   count_en;
  logic   cnt_zero;
  logic   latch_cap;
  logic   latch_zero;
  logic   ovf_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lap_hold_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      lap_hold_q <= lap_hold_n;
      running_q  <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n    = state_q;
    lap_hold_n = lap_hold_q;
    count_en   = 1'b0;
    cnt_zero   = 1'b0;
    latch_cap  = 1'b0;
    latch_zero = 1'b0;
    ovf_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        // start_stop beats clear; the count is already zero in IDLE.
        if (start_stop) begin
          state_n = RUN;
        end else if (clear) begin
          lap_hold_n = 1'b0;
          latch_zero = 1'b0 | 1'b1;
          ovf_clr    = 1'b1;
        end
      end
      RUN: begin
        count_en = tick;
        if (start_stop) state_n = PAUSE;
        if (lap) begin
          lap_hold_n = ~lap_hold_q;
          // Capture uses the registered count, i.e. the pre-increment value
          // when a tick lands on the same edge.
          latch_cap  = ~lap_hold_q;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_n    = IDLE;
          cnt_zero   = 1'b1;
          latch_zero = 1'b1;
          lap_hold_n = 1'b0;
          ovf_clr    = 1'b1;
        end else begin
          if (start_stop) state_n = RUN;
          if (lap) lap_hold_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      latch_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (cnt_zero)      cnt_q <= '0;
      else if (count_en) cnt_q <= cnt_inc;

      if (latch_zero)     latch_q <= '0;
      else if (latch_cap) latch_q <= cnt_q;

      if (ovf_clr)                  overflow_q <= 1'b0;
      else if (count_en && at_max)  overflow_q <= 1'b1;
    end
  end

  assign disp_bcd = lap_hold_q ? latch_q : cnt_q;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule
